// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU control codes, MDU op encoding and MDU FSM states
package alu_pkg;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_ctrl_e;
    typedef enum logic [2:0] {
        MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_MULHU,
        MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU
    } mdu_op_e;
    typedef enum logic [1:0] {IDLE, RUN, DONE} mdu_state_e;
endpackage

// File: rtl/alu_mdu_div.sv
// alu_mdu_div: restoring radix-2 divider on magnitudes, one quotient bit per cycle
module alu_mdu_div #(
    parameter int XLEN = 32,
    parameter int CNTW = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            kill,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quo,
    output logic [XLEN-1:0] rem
);
    logic            busy;
    logic [CNTW-1:0] cnt;
    logic [XLEN-1:0] q, d, r;
    logic [XLEN:0]   r_sh, diff;
    assign r_sh = {r, q[XLEN-1]};
    assign diff = r_sh - {1'b0, d};
    assign done = busy && cnt == CNTW'(XLEN - 1);
    assign quo  = q;
    assign rem  = r;
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
            cnt  <= '0;
            q    <= '0;
            d    <= '0;
            r    <= '0;
        end else if (kill) begin
            busy <= 1'b0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
            q    <= dividend;
            d    <= divisor;
            r    <= '0;
        end else if (busy) begin
            cnt  <= cnt + 1'b1;
            busy <= !done;
            r    <= diff[XLEN] ? r_sh[XLEN-1:0] : diff[XLEN-1:0];
            q    <= {q[XLEN-2:0], ~diff[XLEN]};
        end
    end
endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: iterative M-extension multiply/divide unit; ALU_MDU_FAST_MUL_EN selects a single-cycle multiplier
module alu_mdu
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int CNTW = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            resZero
);
    mdu_state_e        state, state_n;
    mdu_op_e           opc, op_q;
    logic              neg_q, spec_q, acc, is_div, a_sgn, b_sgn, spec_div, run_done, div_done;
    logic [XLEN-1:0]   spec_res, ma, mb, quo, rem, dq, dq_s, fin;
    logic [CNTW-1:0]   cnt;
    logic [2*XLEN-1:0] prod, prod_s;
    assign opc      = mdu_op_e'(op);
    assign is_div   = op[2];
    assign a_sgn    = srcA[XLEN-1] & (opc == MDU_MULH || opc == MDU_MULHSU || opc == MDU_DIV || opc == MDU_REM);
    assign b_sgn    = srcB[XLEN-1] & (opc == MDU_MULH || opc == MDU_DIV || opc == MDU_REM);
    assign ma       = a_sgn ? -srcA : srcA;
    assign mb       = b_sgn ? -srcB : srcB;
    // signed overflow (MIN / -1) and divide-by-zero bypass the iterative divider
    assign spec_div = is_div & (srcB == '0 | (~op[0] & srcA == {1'b1, {(XLEN-1){1'b0}}} & srcB == '1));
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign acc       = in_valid & in_ready & ~flush;
    assign run_done  = op_q[2] ? div_done : cnt == CNTW'(XLEN - 1);
`ifdef ALU_MDU_FAST_MUL_EN
    localparam logic FAST = 1'b1;
    always_ff @(posedge clk) begin
        if (reset) prod <= '0;
        else if (acc) prod <= {{XLEN{1'b0}}, ma} * {{XLEN{1'b0}}, mb};
    end
`else
    localparam logic FAST = 1'b0;
    logic [XLEN-1:0] mc;
    logic [XLEN:0]   sum;
    assign sum = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mc} : '0);
    always_ff @(posedge clk) begin
        if (reset) begin
            prod <= '0;
            mc   <= '0;
        end else if (acc) begin
            prod <= {{XLEN{1'b0}}, mb};
            mc   <= ma;
        end else if (state == RUN && !op_q[2]) begin
            prod <= {sum, prod[XLEN-1:1]};
        end
    end
`endif
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = state;
        if (flush) state_n = IDLE;
        else if (state == IDLE && acc) state_n = (spec_div || (FAST && !is_div)) ? DONE : RUN;
        else if (state == RUN && run_done) state_n = DONE;
        else if (state == DONE && out_ready) state_n = IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= MDU_MUL;
            neg_q    <= 1'b0;
            spec_q   <= 1'b0;
            spec_res <= '0;
            cnt      <= '0;
        end else if (acc) begin
            op_q     <= opc;
            neg_q    <= (op[2] & op[1]) ? a_sgn : a_sgn ^ b_sgn;
            spec_q   <= spec_div;
            spec_res <= srcB == '0 ? (op[1] ? srcA : '1) : (op[1] ? '0 : srcA);
            cnt      <= '0;
        end else if (state == RUN) begin
            cnt      <= cnt + 1'b1;
        end
    end
    alu_mdu_div #(.XLEN(XLEN), .CNTW(CNTW)) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (acc & is_div & ~spec_div),
        .kill     (flush),
        .dividend (ma),
        .divisor  (mb),
        .done     (div_done),
        .quo      (quo),
        .rem      (rem)
    );
    assign prod_s  = neg_q ? -prod : prod;
    assign dq      = op_q[1] ? rem : quo;
    assign dq_s    = neg_q ? -dq : dq;
    assign fin     = spec_q ? spec_res : op_q[2] ? dq_s :
                     op_q == MDU_MUL ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    assign result  = out_valid ? fin : '0;
    assign resZero = result == '0;
endmodule
